// File: rtl/muldiv_seq_ctrl.sv
// Iterative RV32M multiply/divide sequencer.
// One op at a time: shift-add multiply or restoring divide on magnitudes,
// followed by a single sign-fix cycle. The result is held until consumed.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; result_o driven to 0
// CALC  | one radix-2 step per cycle, counter counts down from XLEN
// FIX   | apply signs and select the result half / quotient / remainder
// DONE  | rsp_valid_o high, result_o stable until rsp_ready_i
module muldiv_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       f3_q;
  logic             sign_a_q, sign_b_q;
  logic [XLEN-1:0]  acc_q;   // product high half / partial remainder
  logic [XLEN-1:0]  lo_q;    // multiplier -> product low half / dividend -> quotient
  logic [XLEN-1:0]  opb_q;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]  res_q;

  // request decode
  logic            accept;
  logic            a_signed_form, b_signed_form;
  logic            sign_a_req, sign_b_req;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  // iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_borrow;
  logic [XLEN-1:0]   div_rem_nxt;

  // sign fix
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, fix_res;

  // Decode the incoming request: signedness, magnitudes and the divide corner cases.
  always_comb begin
    accept        = req_valid_i && (state_q == S_IDLE) && !kill_i;
    // MUL/MULH/MULHSU/DIV/REM treat rs1 as signed; MUL/MULH/DIV/REM treat rs2 as signed.
    a_signed_form = funct3_i[2] ? !funct3_i[0] : (funct3_i != 3'd3);
    b_signed_form = funct3_i[2] ? !funct3_i[0] : !funct3_i[1];
    sign_a_req    = a_signed_form && rs1_i[XLEN-1];
    sign_b_req    = b_signed_form && rs2_i[XLEN-1];
    mag_a         = sign_a_req ? -rs1_i : rs1_i;
    mag_b         = sign_b_req ? -rs2_i : rs2_i;
    div_zero      = funct3_i[2] && (rs2_i == '0);
    div_ovf       = funct3_i[2] && !funct3_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);
    special       = div_zero || div_ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (div_zero) special_res = funct3_i[1] ? rs1_i : '1;
    else          special_res = funct3_i[1] ? '0 : rs1_i;
  end

  // One radix-2 step for each of multiply and divide.
  always_comb begin
    mul_sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    mul_nxt     = {mul_sum, lo_q[XLEN-1:1]};
    div_shift   = {acc_q, lo_q[XLEN-1]};
    div_diff    = div_shift - {1'b0, opb_q};
    // the remainder stays below the divisor, so the MSB of the difference is the borrow
    div_borrow  = div_diff[XLEN];
    div_rem_nxt = div_borrow ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
  end

  // Sign correction and result selection used in FIX.
  always_comb begin
    prod   = {acc_q, lo_q};
    prod_s = (sign_a_q ^ sign_b_q) ? -prod : prod;
    quot_s = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    rem_s  = sign_a_q ? -acc_q : acc_q;
    case (f3_q)
      3'd0:                fix_res = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    fix_res = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:          fix_res = quot_s;
      default:             fix_res = rem_s;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and handshake outputs; kill overrides every transition.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    busy_o      = 1'b1;
    result_o    = '0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = !kill_i;
        busy_o      = 1'b0;
        if (accept) state_d = special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        rsp_valid_o = 1'b1;
        result_o    = res_q;
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (kill_i) state_d = S_IDLE;
  end

  // Operand capture, iteration registers and result register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      f3_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      res_q    <= '0;
    end else if (kill_i) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            f3_q     <= funct3_i;
            sign_a_q <= sign_a_req;
            sign_b_q <= sign_b_req;
            acc_q    <= '0;
            lo_q     <= mag_a;
            opb_q    <= mag_b;
            if (special) begin
              cnt_q <= '0;
              res_q <= special_res;
            end else begin
              cnt_q <= CNT_W'(XLEN);
            end
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (f3_q[2]) begin
            acc_q <= div_rem_nxt;
            lo_q  <= {lo_q[XLEN-2:0], !div_borrow};
          end else begin
            {acc_q, lo_q} <= mul_nxt;
          end
        end
        S_FIX: begin
          res_q <= fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule
